// File: rtl/bcd_mod_counter_pkg.sv
// Shared BCD types and helpers for the clock-datapath counter stages.
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t h;
        bcd_t l;
    } bcd2_t;

    localparam bcd_t BCD_MAX_DIGIT = 4'd9;

    // Elaboration-time conversion of a decimal parameter (0..99) to a digit pair.
    function automatic bcd2_t to_bcd2(input int v);
        bcd2_t r;
        r.h = 4'(v / 10);
        r.l = 4'(v % 10);
        return r;
    endfunction

    function automatic logic is_bcd_digit(input bcd_t d);
        return (d <= BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Combinational +/-1 on one BCD digit; carry-in enables the step, carry-out
// flags a 9->0 (up) or 0->9 (down) rollover into the next digit.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    always_comb begin
        q    = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= BCD_MAX_DIGIT) begin
                    q    = 4'd0;
                    cout = 1'b1;
                end else begin
                    q = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    q    = BCD_MAX_DIGIT;
                    cout = 1'b1;
                end else begin
                    q = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter over [MIN_VAL, MAX_VAL] with load, manual step
// and chained carry/borrow. Define BCD_MOD_COUNTER_BLANK_EN to add BLANK_H.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 23,
    parameter int RST_VAL = MIN_VAL
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       INC,
    input  logic       DEC,
    input  logic       LOAD,
    input  logic [3:0] LD_H,
    input  logic [3:0] LD_L,
    output logic [3:0] QH,
    output logic [3:0] QL,
    output logic       CO,
    output logic       BO,
    output logic       LOAD_ERR
`ifdef BCD_MOD_COUNTER_BLANK_EN
    ,
    output logic       BLANK_H
`endif
);

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL || MAX_VAL > 99 ||
        RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_params
        $error("bcd_mod_counter: illegal MIN_VAL/MAX_VAL/RST_VAL combination");
    end

    localparam bcd2_t BCD_MIN = to_bcd2(MIN_VAL);
    localparam bcd2_t BCD_MAX = to_bcd2(MAX_VAL);
    localparam bcd2_t BCD_RST = to_bcd2(RST_VAL);

    bcd2_t count_reg;
    bcd2_t count_next;
    logic  load_err_reg;
    logic  load_err_next;

    logic  man_inc;
    logic  man_dec;
    logic  chain_step;
    logic  step_up;
    logic  at_max;
    logic  at_min;
    logic  load_ok;
    bcd2_t ld_pair;
    bcd2_t stepped;

    bcd_t  digit_cur [2];
    bcd_t  digit_nxt [2];
    logic  carry     [3];

    assign man_inc    = INC & ~DEC;
    assign man_dec    = DEC & ~INC;
    assign chain_step = EN & ~(INC ^ DEC);
    assign step_up    = ~man_dec;

    assign at_max = (count_reg == BCD_MAX);
    assign at_min = (count_reg == BCD_MIN);

    // With both digits valid BCD, an 8-bit compare of the pair is a numeric compare.
    assign ld_pair = {LD_H, LD_L};
    assign load_ok = is_bcd_digit(LD_H) && is_bcd_digit(LD_L) &&
                     (ld_pair >= BCD_MIN) && (ld_pair <= BCD_MAX);

    assign digit_cur[0] = count_reg.l;
    assign digit_cur[1] = count_reg.h;
    assign carry[0]     = 1'b1;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_digit
        bcd_digit_step u_step (
            .d    (digit_cur[gi]),
            .up   (step_up),
            .cin  (carry[gi]),
            .q    (digit_nxt[gi]),
            .cout (carry[gi+1])
        );
    end

    assign stepped = {digit_nxt[1], digit_nxt[0]};

    // A tens rollover (99->00 or 00->99) is only reachable at a range limit,
    // so it is folded into the wrap decision as a guard.
    always_comb begin
        count_next    = count_reg;
        load_err_next = 1'b0;
        if (LOAD) begin
            if (load_ok) begin
                count_next = ld_pair;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (man_inc || chain_step) begin
            count_next = (at_max || carry[2]) ? BCD_MIN : stepped;
        end else if (man_dec) begin
            count_next = (at_min || carry[2]) ? BCD_MAX : stepped;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_reg    <= BCD_RST;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            load_err_reg <= load_err_next;
        end
    end

    assign QH       = count_reg.h;
    assign QL       = count_reg.l;
    assign LOAD_ERR = load_err_reg;

    assign CO = EN & ~RST & ~LOAD & ~(INC ^ DEC) & at_max;
    assign BO = ~RST & ~LOAD & DEC & ~INC & at_min;

`ifdef BCD_MOD_COUNTER_BLANK_EN
    logic blank_h_reg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            blank_h_reg <= (BCD_RST.h == 4'd0);
        end else begin
            blank_h_reg <= (count_next.h == 4'd0);
        end
    end

    assign BLANK_H = blank_h_reg;
`endif

endmodule
